// File: rtl/phase_sequencer.sv
// One-hot phase-enable sequencer with fetch strobe, held core reset and machine-cycle counter; outputs registered, 1-cycle latency.
// Stall freezes the sequence with all enables low; define PHASE_SEQ_GAP_EN to insert a dead cycle after each phase.
module phase_sequencer #(
    parameter int NUM_PHASES  = 2,
    parameter int DIV         = 1,
    parameter int RST_HOLD    = 4,
    parameter int FETCH_PHASE = 0,
    parameter int CNT_W       = 16
) (
    input  logic                  clk,
    input  logic                  rstreq,
    input  logic                  stall,
    output logic [NUM_PHASES-1:0] phase,
    output logic                  fetch,
    output logic                  rst,
    output logic                  running,
    output logic [CNT_W-1:0]      mcycle
);

    localparam int IDX_W  = (NUM_PHASES > 2) ? $clog2(NUM_PHASES) : 1;
    localparam int DIV_W  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int HOLD_W = (RST_HOLD > 1) ? $clog2(RST_HOLD) : 1;

    localparam logic [IDX_W-1:0]      LAST_IDX  = IDX_W'(NUM_PHASES - 1);
    localparam logic [IDX_W-1:0]      FETCH_IDX = IDX_W'(FETCH_PHASE);
    localparam logic [DIV_W-1:0]      DIV_LAST  = DIV_W'(DIV - 1);
    localparam logic [HOLD_W-1:0]     HOLD_LAST = HOLD_W'(RST_HOLD - 1);
    localparam logic [NUM_PHASES-1:0] ONE       = NUM_PHASES'(1);

`ifdef PHASE_SEQ_GAP_EN
    localparam logic GAP_EN = 1'b1;
`else
    localparam logic GAP_EN = 1'b0;
`endif

    generate
        if (NUM_PHASES < 2 || NUM_PHASES > 8) begin : g_err_num_phases
            $error("phase_sequencer: NUM_PHASES must be in 2..8");
        end
        if (DIV < 1) begin : g_err_div
            $error("phase_sequencer: DIV must be >= 1");
        end
        if (RST_HOLD < 1) begin : g_err_rst_hold
            $error("phase_sequencer: RST_HOLD must be >= 1");
        end
        if (FETCH_PHASE < 0 || FETCH_PHASE >= NUM_PHASES) begin : g_err_fetch_phase
            $error("phase_sequencer: FETCH_PHASE must be < NUM_PHASES");
        end
        if (CNT_W < 1) begin : g_err_cnt_w
            $error("phase_sequencer: CNT_W must be >= 1");
        end
    endgenerate

    typedef enum logic [1:0] {
        RESET = 2'd0,
        HOLD  = 2'd1,
        RUN   = 2'd2
    } state_t;

    state_t                  state_q, state_d;
    logic [HOLD_W-1:0]       hold_q, hold_d;
    logic [DIV_W-1:0]        div_q, div_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic                    gap_q, gap_d;
    logic                    fired_q, fired_d;
    logic [CNT_W-1:0]        mcycle_q, mcycle_d;
    logic [NUM_PHASES-1:0]   phase_q, phase_d;
    logic                    fetch_q, fetch_d;
    logic                    rst_q, rst_d;
    logic                    running_q, running_d;
    logic                    adv;
    logic                    show;

    always_comb begin
        state_d   = state_q;
        hold_d    = hold_q;
        div_d     = div_q;
        idx_d     = idx_q;
        gap_d     = gap_q;
        fired_d   = fired_q;
        mcycle_d  = mcycle_q;
        rst_d     = rst_q;
        running_d = running_q;
        phase_d   = '0;
        fetch_d   = 1'b0;
        adv       = 1'b0;
        show      = 1'b0;

        case (state_q)
            RESET: state_d = HOLD;
            HOLD: begin
                if (hold_q == HOLD_LAST) begin
                    state_d   = RUN;
                    rst_d     = 1'b0;
                    running_d = 1'b1;
                    idx_d     = '0;
                    div_d     = '0;
                    gap_d     = 1'b0;
                    fired_d   = 1'b0;
                    show      = !stall;
                end else begin
                    hold_d = hold_q + 1'b1;
                end
            end
            RUN: begin
                // phase_q == 0 outside a gap means the previous cycle was stalled: re-show the frozen phase
                if (!stall) begin
                    if (gap_q) begin
                        gap_d = 1'b0;
                        adv   = 1'b1;
                        show  = 1'b1;
                    end else if (phase_q == '0) begin
                        show = 1'b1;
                    end else if (div_q == DIV_LAST) begin
                        div_d = '0;
                        if (GAP_EN) begin
                            gap_d = 1'b1;
                        end else begin
                            adv  = 1'b1;
                            show = 1'b1;
                        end
                    end else begin
                        div_d = div_q + 1'b1;
                        show  = 1'b1;
                    end
                end
            end
            default: state_d = RESET;
        endcase

        if (adv) begin
            fired_d = 1'b0;
            if (idx_q == LAST_IDX) begin
                idx_d    = '0;
                mcycle_d = mcycle_q + 1'b1;
            end else begin
                idx_d = idx_q + 1'b1;
            end
        end

        // fired_q marks that the current occupancy already produced its fetch pulse
        if (show) begin
            phase_d = ONE << idx_d;
            if (idx_d == FETCH_IDX && !fired_d) begin
                fetch_d = 1'b1;
                fired_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rstreq) begin
        if (rstreq) begin
            state_q   <= RESET;
            hold_q    <= '0;
            div_q     <= '0;
            idx_q     <= '0;
            gap_q     <= 1'b0;
            fired_q   <= 1'b0;
            mcycle_q  <= '0;
            phase_q   <= '0;
            fetch_q   <= 1'b0;
            rst_q     <= 1'b1;
            running_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            hold_q    <= hold_d;
            div_q     <= div_d;
            idx_q     <= idx_d;
            gap_q     <= gap_d;
            fired_q   <= fired_d;
            mcycle_q  <= mcycle_d;
            phase_q   <= phase_d;
            fetch_q   <= fetch_d;
            rst_q     <= rst_d;
            running_q <= running_d;
        end
    end

    assign phase   = phase_q;
    assign fetch   = fetch_q;
    assign rst     = rst_q;
    assign running = running_q;
    assign mcycle  = mcycle_q;

endmodule

// File: tb/tb_phase_sequencer.sv
// Bench for phase_sequencer: two configurations driven with shared rstreq/stall and checked every cycle
// against a slot-based reference model (a machine cycle is a list of phase slots, optionally with gap slots).
module tb_phase_sequencer;

    logic clk = 1'b0;
    logic rstreq;
    logic stall;

    logic [1:0]  pha;
    logic        fa, ra, runa;
    logic [15:0] mca;
    logic [3:0]  phb;
    logic        fb, rb, runb;
    logic [3:0]  mcb;

    always #5 clk = ~clk;

    phase_sequencer u_a (
        .clk(clk), .rstreq(rstreq), .stall(stall),
        .phase(pha), .fetch(fa), .rst(ra), .running(runa), .mcycle(mca)
    );

    phase_sequencer #(
        .NUM_PHASES(4), .DIV(3), .RST_HOLD(2), .FETCH_PHASE(2), .CNT_W(4)
    ) u_b (
        .clk(clk), .rstreq(rstreq), .stall(stall),
        .phase(phb), .fetch(fb), .rst(rb), .running(runb), .mcycle(mcb)
    );

`ifdef PHASE_SEQ_GAP_EN
    localparam int GAP = 1;
`else
    localparam int GAP = 0;
`endif

    int np [2] = '{2, 4};
    int dv [2] = '{1, 3};
    int rh [2] = '{4, 2};
    int fp [2] = '{0, 2};
    int cw [2] = '{16, 4};

    // Model state: edges seen since release, current slot index, last fetched occurrence.
    int e [2];
    int k [2];
    int last_occ [2];
    bit run [2];
    bit resume [2];
    int ephase [2];
    bit efetch [2];

    int checks = 0;
    int errors = 0;

    function automatic int sl(input int i);
        return dv[i] + GAP;
    endfunction

    function automatic int per(input int i);
        return np[i] * sl(i);
    endfunction

    function automatic bit is_gap(input int i, input int kk);
        return (GAP == 1) && ((kk % sl(i)) == dv[i]);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            e[i] = 0; k[i] = 0; last_occ[i] = -1;
            run[i] = 1'b0; resume[i] = 1'b0;
            ephase[i] = 0; efetch[i] = 1'b0;
        end
    endtask

    task automatic model_edge(input int i);
        int p;
        efetch[i] = 1'b0;
        if (e[i] < rh[i]) begin
            e[i]++;
            ephase[i] = 0;
            return;
        end
        if (!run[i]) begin
            run[i] = 1'b1; k[i] = 0; resume[i] = 1'b1;
        end
        if (stall) begin
            ephase[i] = 0;
            resume[i] = 1'b1;
            return;
        end
        // stalled cycles already supply dead time, so a frozen gap slot is not shown again
        if (resume[i]) begin
            resume[i] = 1'b0;
            if (is_gap(i, k[i])) k[i]++;
        end else begin
            k[i]++;
        end
        if (is_gap(i, k[i])) begin
            ephase[i] = 0;
        end else begin
            p = (k[i] % per(i)) / sl(i);
            ephase[i] = 1 << p;
            if (p == fp[i] && (k[i] / sl(i)) != last_occ[i]) begin
                efetch[i] = 1'b1;
                last_occ[i] = k[i] / sl(i);
            end
        end
    endtask

    function automatic int exp_mcycle(input int i);
        return (k[i] / per(i)) % (1 << cw[i]);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("a_phase",   32'(pha),  32'(ephase[0]));
        chk("a_fetch",   32'(fa),   32'(efetch[0]));
        chk("a_rst",     32'(ra),   32'(!run[0]));
        chk("a_running", 32'(runa), 32'(run[0]));
        chk("a_mcycle",  32'(mca),  32'(exp_mcycle(0)));
        chk("a_onehot",  32'($countones(pha) <= 1), 32'd1);
        chk("b_phase",   32'(phb),  32'(ephase[1]));
        chk("b_fetch",   32'(fb),   32'(efetch[1]));
        chk("b_rst",     32'(rb),   32'(!run[1]));
        chk("b_running", 32'(runb), 32'(run[1]));
        chk("b_mcycle",  32'(mcb),  32'(exp_mcycle(1)));
        chk("b_onehot",  32'($countones(phb) <= 1), 32'd1);
    endtask

    task automatic step();
        @(posedge clk);
        if (rstreq) begin
            model_reset();
        end else begin
            model_edge(0);
            model_edge(1);
        end
        @(negedge clk);
        check_all();
    endtask

    initial begin
        rstreq = 1'b1;
        stall  = 1'b0;
        model_reset();
        step();
        step();

        // release and free-run: reset hold, first phases, first fetch, first mcycle wraps
        rstreq = 1'b0;
        repeat (40) step();

        // asynchronous reset while A shows phase 1
        for (int i = 0; i < 10 && ephase[0] != 2; i++) step();
        #2 rstreq = 1'b1;
        model_reset();
        #1 check_all();
        step();
        step();
        rstreq = 1'b0;

        // stall 5 cycles starting right after A first shows phase 0
        repeat (5) step();
        stall = 1'b1;
        repeat (5) step();
        stall = 1'b0;
        repeat (20) step();

        // sub-cycle glitch on rstreq still restarts the full hold sequence
        repeat (7) step();
        #1 rstreq = 1'b1;
        #1 model_reset();
        check_all();
        #1 rstreq = 1'b0;
        repeat (30) step();

        // random stalls, then a long unstalled run to wrap B's 4-bit counter
        repeat (600) begin
            stall = ($urandom_range(0, 3) == 0);
            step();
        end
        stall = 1'b0;
        repeat (250) step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
